// File: rtl/mem_ctrl_if.sv
// Request/response bus between the CPU memory stage (master) and the
// data-memory controller (slave).
interface mem_ctrl_if;
  logic        r_enable_i;
  logic        w_enable_i;
  logic [3:0]  w_mask_i;
  logic [31:0] w_data_i;
  logic [31:0] addr_i;
  logic [31:0] r_data_o;
  logic        busy_o;
  logic        done_o;

  modport master (
    output r_enable_i, w_enable_i, w_mask_i, w_data_i, addr_i,
    input  r_data_o, busy_o, done_o
  );

  modport slave (
    input  r_enable_i, w_enable_i, w_mask_i, w_data_i, addr_i,
    output r_data_o, busy_o, done_o
  );
endinterface

// File: rtl/mem_ctrl.sv
// Data-memory controller: turns word load/store requests into byte
// transactions on an 8-bit synchronous external memory port.
// Reads take 4 address cycles plus one trailing capture cycle; writes take
// one cycle per enabled byte lane. A single DONE cycle pulses done_o.
module mem_ctrl #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  mem_ctrl_if.slave         req,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic [7:0]        mem_dout_o,
  output logic              mem_wr_o,
  input  logic [7:0]        mem_din_i
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state;
  logic [ADDR_W-3:0] base_hi;
  logic [3:0]        mask_q;
  logic [31:0]       wdata_q;
  logic [2:0]        idx;

  // Lowest set lane at or above 'from'; 4 means no lane left.
  function automatic logic [2:0] next_lane(input logic [3:0] mask, input logic [2:0] from);
    logic [2:0] r;
    r = 3'd4;
    for (int k = 3; k >= 0; k--) begin
      if (mask[k] && (3'(k) >= from)) r = 3'(k);
    end
    return r;
  endfunction

  // Byte of a word on the given lane.
  function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] lane);
    return w[{lane, 3'b000} +: 8];
  endfunction

  logic [2:0] first_lane;
  logic [2:0] nxt_lane;
  logic [1:0] cap_lane;

  assign first_lane = next_lane(req.w_mask_i, 3'd0);
  assign nxt_lane   = next_lane(mask_q, idx + 3'd1);
  // In READ, idx counts cycles 0..4; the byte arriving now belongs to the
  // address issued one cycle earlier (idx-1; idx=4 wraps to lane 3).
  assign cap_lane   = idx[1:0] - 2'd1;

  // Controller FSM with registered bus and memory-port outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      req.busy_o   <= 1'b0;
      req.done_o   <= 1'b0;
      req.r_data_o <= '0;
      mem_wr_o     <= 1'b0;
      mem_a_o      <= '0;
      mem_dout_o   <= '0;
      idx          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req.r_enable_i) begin
            base_hi    <= req.addr_i[ADDR_W-1:2];
            mem_a_o    <= {req.addr_i[ADDR_W-1:2], 2'b00};
            idx        <= 3'd0;
            req.busy_o <= 1'b1;
            state      <= READ;
          end else if (req.w_enable_i) begin
            base_hi <= req.addr_i[ADDR_W-1:2];
            mask_q  <= req.w_mask_i;
            wdata_q <= req.w_data_i;
            if (first_lane[2]) begin
              // Empty mask: complete without touching memory.
              req.done_o <= 1'b1;
              state      <= DONE;
            end else begin
              idx        <= first_lane;
              mem_a_o    <= {req.addr_i[ADDR_W-1:2], first_lane[1:0]};
              mem_dout_o <= lane_byte(req.w_data_i, first_lane[1:0]);
              mem_wr_o   <= 1'b1;
              req.busy_o <= 1'b1;
              state      <= WRITE;
            end
          end
        end

        READ: begin
          if (idx != 3'd0) req.r_data_o[{cap_lane, 3'b000} +: 8] <= mem_din_i;
          if (idx < 3'd3) mem_a_o <= {base_hi, idx[1:0] + 2'd1};
          if (idx == 3'd4) begin
            idx        <= 3'd0;
            req.busy_o <= 1'b0;
            req.done_o <= 1'b1;
            state      <= DONE;
          end else begin
            idx <= idx + 3'd1;
          end
        end

        WRITE: begin
          if (nxt_lane[2]) begin
            idx        <= 3'd0;
            mem_wr_o   <= 1'b0;
            req.busy_o <= 1'b0;
            req.done_o <= 1'b1;
            state      <= DONE;
          end else begin
            idx        <= nxt_lane;
            mem_a_o    <= {base_hi, nxt_lane[1:0]};
            mem_dout_o <= lane_byte(wdata_q, nxt_lane[1:0]);
          end
        end

        default: begin
          req.done_o <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: synchronous byte RAM, a transaction-level model that
// schedules the expected outputs per cycle, and literal spot checks.
module tb_mem_ctrl;
  localparam int ADDR_W = 17;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_ctrl_if bus ();
  logic [ADDR_W-1:0] mem_a_o;
  logic [7:0]        mem_dout_o;
  logic [7:0]        mem_din_i;
  logic              mem_wr_o;

  mem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (bus),
    .mem_a_o   (mem_a_o),
    .mem_dout_o(mem_dout_o),
    .mem_wr_o  (mem_wr_o),
    .mem_din_i (mem_din_i)
  );

  function automatic logic [7:0] init_byte(input int a);
    case (a)
      'h100: return 8'h11;
      'h101: return 8'h22;
      'h102: return 8'h33;
      'h103: return 8'h44;
      'h300: return 8'hA0;
      'h301: return 8'hA1;
      'h302: return 8'hA2;
      'h303: return 8'hA3;
      default: return 8'h00;
    endcase
  endfunction

  // External synchronous RAM: read data appears the cycle after the address.
  logic [7:0] ram [0:1023];
  logic       preload = 1'b1;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) ram[i] <= init_byte(i);
      mem_din_i <= 8'h00;
    end else begin
      if (mem_wr_o) ram[mem_a_o[9:0]] <= mem_dout_o;
      mem_din_i <= ram[mem_a_o[9:0]];
    end
  end

  typedef struct {
    bit                busy;
    bit                done;
    bit                wr;
    bit                chk_a;
    bit                chk_rd;
    logic [ADDR_W-1:0] a;
    logic [7:0]        dout;
    logic [31:0]       rd;
  } exp_t;

  exp_t       exp_tab [int];
  logic [7:0] model_mem [0:1023];
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, req);
    end
  endfunction

  // Compare this cycle's DUT outputs with the scheduled expectation
  // (no entry means the controller must be quiet).
  task automatic cmp_cycle();
    exp_t e;
    e = '{default: 0};
    if (exp_tab.exists(cyc)) e = exp_tab[cyc];
    chk("busy_o", 32'(bus.busy_o), 32'(e.busy));
    chk("done_o", 32'(bus.done_o), 32'(e.done));
    chk("mem_wr_o", 32'(mem_wr_o), 32'(e.wr));
    if (e.chk_a) chk("mem_a_o", 32'(mem_a_o), 32'(e.a));
    if (e.wr) chk("mem_dout_o", 32'(mem_dout_o), 32'(e.dout));
    if (e.chk_rd) chk("r_data_o", bus.r_data_o, e.rd);
  endtask

  task automatic step();
    @(negedge clk);
    cmp_cycle();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // Read accepted on the edge after cycle k: addresses base..base+3 in the
  // next four cycles, one more busy cycle, then the done cycle.
  task automatic push_read(input int k, input logic [31:0] addr);
    exp_t e;
    int base;
    logic [31:0] rd;
    base = int'({addr[ADDR_W-1:2], 2'b00});
    for (int i = 0; i < 4; i++) rd[8*i +: 8] = model_mem[base + i];
    for (int j = 1; j <= 4; j++) begin
      e = '{default: 0};
      e.busy = 1; e.chk_a = 1; e.a = ADDR_W'(base + j - 1);
      exp_tab[k + j] = e;
    end
    e = '{default: 0};
    e.busy = 1;
    exp_tab[k + 5] = e;
    e = '{default: 0};
    e.done = 1; e.chk_rd = 1; e.rd = rd;
    exp_tab[k + 6] = e;
  endtask

  // Write accepted on the edge after cycle k: one cycle per set lane, then
  // done. Only the first nmax lanes happen (a reset cuts the rest).
  task automatic push_write(input int k, input logic [31:0] addr, input logic [3:0] mask,
                            input logic [31:0] data, input int nmax);
    exp_t e;
    int base;
    int n;
    bit cut;
    base = int'({addr[ADDR_W-1:2], 2'b00});
    n = 0;
    cut = 0;
    for (int lane = 0; lane < 4; lane++) begin
      if (mask[lane]) begin
        if (n < nmax) begin
          n++;
          e = '{default: 0};
          e.busy = 1; e.wr = 1; e.chk_a = 1;
          e.a = ADDR_W'(base + lane);
          e.dout = data[8*lane +: 8];
          exp_tab[k + n] = e;
          model_mem[base + lane] = data[8*lane +: 8];
        end else begin
          cut = 1;
        end
      end
    end
    if (!cut) begin
      e = '{default: 0};
      e.done = 1;
      exp_tab[k + n + 1] = e;
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
    push_write(cyc, addr, mask, data, 4);
    bus.w_enable_i = 1'b1;
    bus.addr_i     = addr;
    bus.w_mask_i   = mask;
    bus.w_data_i   = data;
    step();
    bus.w_enable_i = 1'b0;
    bus.addr_i     = 32'h0001_FFFC;
    bus.w_mask_i   = 4'hF;
    bus.w_data_i   = 32'h5555_AAAA;
    idle(7);
  endtask

  int k;

  initial begin
    bus.r_enable_i = 1'b0;
    bus.w_enable_i = 1'b0;
    bus.w_mask_i   = 4'h0;
    bus.w_data_i   = 32'h0;
    bus.addr_i     = 32'h0;
    for (int i = 0; i < 1024; i++) model_mem[i] = init_byte(i);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_done", 32'(bus.done_o), 32'd0);
    chk("rst_wr", 32'(mem_wr_o), 32'd0);
    chk("rst_rdata", bus.r_data_o, 32'd0);
    chk("rst_addr", 32'(mem_a_o), 32'd0);
    chk("rst_dout", 32'(mem_dout_o), 32'd0);
    preload = 1'b0;
    rst = 1'b0;
    cyc = 0;
    idle(2);

    // Word read at unaligned address 0x102; address changes after accept.
    k = cyc;
    push_read(k, 32'h102);
    bus.r_enable_i = 1'b1;
    bus.addr_i     = 32'h102;
    step();
    bus.r_enable_i = 1'b0;
    bus.addr_i     = 32'h0000_0FFC;
    idle(8);
    chk("rdata_lit", bus.r_data_o, 32'h4433_2211);

    // Full-word store.
    do_write(32'h200, 4'b1111, 32'hDEAD_BEEF);
    chk("ram200", 32'(ram['h200]), 32'hEF);
    chk("ram201", 32'(ram['h201]), 32'hBE);
    chk("ram202", 32'(ram['h202]), 32'hAD);
    chk("ram203", 32'(ram['h203]), 32'hDE);
    chk("rdata_held", bus.r_data_o, 32'h4433_2211);

    // Byte and halfword stores.
    do_write(32'h301, 4'b0010, 32'h5A5A_5A5A);
    do_write(32'h302, 4'b1100, 32'h7777_7777);
    chk("ram300", 32'(ram['h300]), 32'hA0);
    chk("ram301", 32'(ram['h301]), 32'h5A);
    chk("ram302", 32'(ram['h302]), 32'h77);
    chk("ram303", 32'(ram['h303]), 32'h77);

    // Empty mask and split mask.
    do_write(32'h204, 4'b0000, 32'hFFFF_FFFF);
    chk("ram204", 32'(ram['h204]), 32'h00);
    do_write(32'h380, 4'b1001, 32'h1122_3344);
    chk("ram380", 32'(ram['h380]), 32'h44);
    chk("ram381", 32'(ram['h381]), 32'h00);
    chk("ram382", 32'(ram['h382]), 32'h00);
    chk("ram383", 32'(ram['h383]), 32'h11);

    // Read and write together, held through DONE: two reads, no write.
    k = cyc;
    push_read(k, 32'h300);
    push_read(k + 7, 32'h300);
    bus.r_enable_i = 1'b1;
    bus.w_enable_i = 1'b1;
    bus.addr_i     = 32'h300;
    bus.w_mask_i   = 4'hF;
    bus.w_data_i   = 32'h1234_5678;
    repeat (8) step();
    bus.r_enable_i = 1'b0;
    bus.w_enable_i = 1'b0;
    idle(9);
    chk("rdata_both", bus.r_data_o, 32'h7777_5AA0);

    // Reset during the second cycle of a full-word store.
    k = cyc;
    push_write(k, 32'h3C0, 4'b1111, 32'hCAFE_F00D, 2);
    bus.w_enable_i = 1'b1;
    bus.addr_i     = 32'h3C0;
    bus.w_mask_i   = 4'hF;
    bus.w_data_i   = 32'hCAFE_F00D;
    step();
    bus.w_enable_i = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", 32'(bus.busy_o), 32'd0);
    chk("abort_wr", 32'(mem_wr_o), 32'd0);
    idle(6);
    chk("ram3c0", 32'(ram['h3C0]), 32'h0D);
    chk("ram3c1", 32'(ram['h3C1]), 32'hF0);
    chk("ram3c2", 32'(ram['h3C2]), 32'h00);
    chk("ram3c3", 32'(ram['h3C3]), 32'h00);

    // Whole RAM must match the model's view of memory.
    for (int i = 0; i < 1024; i++) chk("ram_sweep", 32'(ram[i]), 32'(model_mem[i]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Responder side of the CPU data-memory request interface; serves word-level load/store requests from the memory stage.
- Converts each request into a sequence of transactions on an 8-bit synchronous external memory port.
- Reports progress back to the requester on `busy_o` and `done_o`.
- Sits between the memory stage and the board/simulation RAM.

Parameters:
- ADDR_W, 17, width of external byte address bus; request address bits above ADDR_W-1 are ignored.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- r_enable_i  input  1  read request (word read at aligned address)
- w_enable_i  input  1  write request (masked word write)
- w_mask_i  input  4  byte-lane write mask, bit k = lane k
- w_data_i  input  32  write data, lane k = w_data_i[8k+7:8k]
- addr_i  input  32  request byte address; bits [1:0] ignored
- r_data_o  output  32  assembled read word, lane k from byte base+k
- busy_o  output  1  transaction in progress
- done_o  output  1  one-cycle completion pulse
- mem_a_o  output  ADDR_W  external byte address
- mem_dout_o  output  8  external write data
- mem_wr_o  output  1  external write strobe (1 = write this cycle)
- mem_din_i  input  8  external read data, valid the cycle after the address is presented

Behaviour:
- Reset values on the edge where rst=1, taking priority over everything:
  - state=IDLE; busy_o=0, done_o=0, mem_wr_o=0.
  - r_data_o=0, mem_a_o=0, mem_dout_o=0; byte index=0.
- Reset mid-transaction aborts it: no done_o pulse, no further mem_wr_o, partially written bytes stay written.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - Requests are sampled only in IDLE.
  - r_enable_i=1 → latch base={addr_i[ADDR_W-1:2],2'b00}, go to READ, idx=0.
  - Else w_enable_i=1 → latch base, w_mask_i and w_data_i, then go to WRITE with idx = lowest set mask bit.
  - Both requests asserted → read wins, write is dropped (illegal by protocol; no error flag).
  - w_enable_i with mask 0000 → go directly to DONE, no memory access.
- busy_o: 1 in READ and WRITE, 0 in IDLE and DONE.
- READ:
  - Issue cycles i=0..3: mem_a_o=base+i, mem_wr_o=0.
  - Byte i is captured from mem_din_i on the edge ending the cycle after address i, into r_data_o[8i+7:8i].
  - After capturing byte 3 → DONE.
  - Accept edge E0; done_o is high in the cycle after E5 (6 cycles).
- WRITE:
  - One cycle per set mask bit, ascending lane order; clear lanes are skipped with no idle cycle.
  - Each such cycle drives mem_a_o=base+idx, mem_dout_o=lane idx of latched data, mem_wr_o=1.
  - After the highest set lane → DONE.
  - Latency: N set bits → done_o in cycle N+1 after the accept edge.
- DONE:
  - done_o=1 for exactly one cycle, then unconditionally IDLE.
  - Requests are ignored in DONE.
  - r_data_o is valid in DONE and held until the next read overwrites it; it is unaffected by writes.
- mem_wr_o is 0 in every state except WRITE.
- Back-to-back: the earliest next acceptance is the IDLE cycle after DONE.
- The latched request is stable for the whole transaction; changes on input ports during READ/WRITE have no effect.
- Address wrap: base+i never carries into bits above [1:0] because base is aligned.

Test Plan:
- Memory bytes 0x100..0x103 = 11,22,33,44; r_enable_i with addr_i=0x102:
  - mem_a_o sequence 0x100..0x103.
  - done_o pulse 6 cycles after accept.
  - r_data_o=0x44332211; busy_o high for 5 cycles.
- w_enable_i, addr 0x200, mask 1111, data 0xDEADBEEF:
  - 4 write cycles: 0x200=EF, 0x201=BE, 0x202=AD, 0x203=DE.
  - done_o in cycle 5.
- Masks 0010 (SB to 0x301) and 1100 (SH to 0x302), data replicated:
  - Only 0x301, then 0x302/0x303, are written; other bytes unchanged.
  - done_o after 2 and 3 cycles respectively.
- Mask 0000 and mask 1001:
  - 0000: no mem_wr_o, done_o next cycle.
  - 1001: writes base+0 then base+3 in consecutive cycles.
- r_enable_i and w_enable_i asserted together:
  - Read performed, no mem_wr_o.
  - A request held high through DONE is re-accepted only in the following IDLE cycle.
- rst asserted during the 2nd write cycle of a mask-1111 store:
  - Next cycle is IDLE with busy_o=0 and mem_wr_o=0.
  - No done_o pulse; only bytes 0 and 1 modified.
